// File: rtl/local_sp_uram_arbiter.sv
// Round-robin arbiter sharing one single-port URAM buffer between the DMA loader (write)
// and the kNN compute stage (read), with a fixed-latency read return path.
module local_sp_uram_arbiter #(
   parameter int DataWidth    = 256,
   parameter int AddressWidth = 11,
   parameter int AddressRange = 2048,
   parameter int RdLatency    = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_req_valid,
   output logic                    wr_req_ready,
   input  logic [AddressWidth-1:0] wr_addr,
   input  logic [DataWidth-1:0]    wr_data,
   input  logic                    rd_req_valid,
   output logic                    rd_req_ready,
   input  logic [AddressWidth-1:0] rd_addr,
   output logic                    rd_rsp_valid,
   output logic [DataWidth-1:0]    rd_rsp_data,
   output logic [2:0]              rd_inflight,
   output logic [AddressWidth-1:0] mem_address0,
   output logic                    mem_ce0,
   output logic                    mem_we0,
   output logic [DataWidth-1:0]    mem_d0,
   input  logic [DataWidth-1:0]    mem_q0
);

   // state   | meaning
   // PRI_RD  | read requester wins when both are valid
   // PRI_WR  | write requester wins when both are valid
   typedef enum logic {
      PRI_RD = 1'b0,
      PRI_WR = 1'b1
   } pri_t;

   pri_t                 pri_q;
   pri_t                 pri_d;
   logic                 grant_wr;
   logic                 grant_rd;
   logic [RdLatency-1:0] vpipe;
   logic                 tail;

   if (RdLatency < 1 || RdLatency > 4) begin : g_bad_latency
      $error("RdLatency must be in 1..4");
   end
   if (AddressRange > (1 << AddressWidth)) begin : g_bad_range
      $error("AddressRange exceeds the address width");
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pri_q <= PRI_RD;
      end else begin
         pri_q <= pri_d;
      end
   end

   // Grants are gated by reset so nothing reaches the memory while the block is held in reset.
   always_comb begin
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      pri_d    = pri_q;
      if (reset) begin
         if (wr_req_valid && (!rd_req_valid || pri_q == PRI_WR)) begin
            grant_wr = 1'b1;
            pri_d    = PRI_RD;
         end else if (rd_req_valid) begin
            grant_rd = 1'b1;
            pri_d    = PRI_WR;
         end
      end
   end

   assign wr_req_ready = grant_wr;
   assign rd_req_ready = grant_rd;
   assign mem_ce0      = grant_wr | grant_rd;
   assign mem_we0      = grant_wr;
   assign mem_address0 = grant_rd ? rd_addr : wr_addr;
   assign mem_d0       = wr_data;

   always_ff @(posedge clk) begin
      if (!reset) begin
         vpipe <= '0;
      end else begin
         vpipe[0] <= grant_rd;
         for (int i = 1; i < RdLatency; i++) begin
            vpipe[i] <= vpipe[i-1];
         end
      end
   end

   assign tail = vpipe[RdLatency-1];

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_rsp_valid <= 1'b0;
         rd_rsp_data  <= '0;
      end else begin
         rd_rsp_valid <= tail;
         if (tail) begin
            rd_rsp_data <= mem_q0;
         end
      end
   end

   // A read counts as in flight until its response pulse has been presented.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_inflight <= 3'd0;
      end else begin
         case ({grant_rd, rd_rsp_valid})
            2'b10:   rd_inflight <= rd_inflight + 3'd1;
            2'b01:   rd_inflight <= rd_inflight - 3'd1;
            default: rd_inflight <= rd_inflight;
         endcase
      end
   end

endmodule

// File: tb/tb_local_sp_uram_arbiter.sv
// Directed bench for local_sp_uram_arbiter with a two-stage registered URAM model
// matching RdLatency = 2.
module tb_local_sp_uram_arbiter;
   localparam int DW  = 256;
   localparam int AW  = 11;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_req_valid;
   logic          wr_req_ready;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          rd_req_valid;
   logic          rd_req_ready;
   logic [AW-1:0] rd_addr;
   logic          rd_rsp_valid;
   logic [DW-1:0] rd_rsp_data;
   logic [2:0]    rd_inflight;
   logic [AW-1:0] mem_address0;
   logic          mem_ce0;
   logic          mem_we0;
   logic [DW-1:0] mem_d0;
   logic [DW-1:0] mem_q0 = '0;

   logic [DW-1:0] ram [0:2047] = '{default: '0};
   logic [DW-1:0] q_s1 = '0;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   local_sp_uram_arbiter #(
      .DataWidth   (DW),
      .AddressWidth(AW),
      .AddressRange(2048),
      .RdLatency   (LAT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_req_valid(wr_req_valid),
      .wr_req_ready(wr_req_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_req_valid(rd_req_valid),
      .rd_req_ready(rd_req_ready),
      .rd_addr     (rd_addr),
      .rd_rsp_valid(rd_rsp_valid),
      .rd_rsp_data (rd_rsp_data),
      .rd_inflight (rd_inflight),
      .mem_address0(mem_address0),
      .mem_ce0     (mem_ce0),
      .mem_we0     (mem_we0),
      .mem_d0      (mem_d0),
      .mem_q0      (mem_q0)
   );

   always @(posedge clk) begin
      if (mem_ce0) begin
         if (mem_we0) ram[mem_address0] <= mem_d0;
         else         q_s1 <= ram[mem_address0];
      end
      mem_q0 <= q_s1;
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      int n_w;
      int n_r;
      int n_rsp;
      int peak;
      int exp_inf[11] = '{0, 1, 2, 3, 3, 3, 3, 2, 1, 0, 0};
      int exp_one[5]  = '{0, 1, 1, 1, 0};
      logic [DW-1:0] pat_a5;
      logic          exp_v;

      pat_a5       = {32{8'hA5}};
      reset        = 1'b0;
      wr_req_valid = 1'b1;
      rd_req_valid = 1'b1;
      wr_addr      = '0;
      wr_data      = '0;
      rd_addr      = '0;

      // reset held low with both requesters asserting
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rst_wr_ready", 256'(wr_req_ready), 256'(0));
         chk("rst_rd_ready", 256'(rd_req_ready), 256'(0));
         chk("rst_ce0", 256'(mem_ce0), 256'(0));
         chk("rst_rsp_valid", 256'(rd_rsp_valid), 256'(0));
         chk("rst_inflight", 256'(rd_inflight), 256'(0));
      end

      reset        = 1'b1;
      wr_req_valid = 1'b0;
      rd_req_valid = 1'b0;
      wr_addr      = 11'd7;
      tick();
      settle();
      chk("idle_ce0", 256'(mem_ce0), 256'(0));
      chk("idle_we0", 256'(mem_we0), 256'(0));
      chk("idle_addr", 256'(mem_address0), 256'(7));

      // contention from reset: R,W,R,W,...
      n_w   = 0;
      n_r   = 0;
      n_rsp = 0;
      for (int c = 0; c < 8; c++) begin
         wr_req_valid = 1'b1;
         rd_req_valid = 1'b1;
         wr_addr      = AW'(100 + c);
         wr_data      = DW'(c);
         rd_addr      = 11'd200;
         settle();
         chk("cont_rd_ready", 256'(rd_req_ready), 256'((c % 2) == 0));
         chk("cont_wr_ready", 256'(wr_req_ready), 256'((c % 2) == 1));
         chk("cont_we0", 256'(mem_we0), 256'((c % 2) == 1));
         chk("cont_ce0", 256'(mem_ce0), 256'(1));
         if (wr_req_ready) n_w++;
         if (rd_req_ready) n_r++;
         if (rd_rsp_valid) n_rsp++;
         tick();
      end
      wr_req_valid = 1'b0;
      rd_req_valid = 1'b0;
      for (int c = 8; c < 12; c++) begin
         settle();
         if (rd_rsp_valid) n_rsp++;
         tick();
      end
      chk("cont_writes", 256'(n_w), 256'(4));
      chk("cont_reads", 256'(n_r), 256'(4));
      chk("cont_responses", 256'(n_rsp), 256'(4));
      chk("cont_inflight_end", 256'(rd_inflight), 256'(0));

      // single write then read of address 5
      wr_req_valid = 1'b1;
      wr_addr      = 11'd5;
      wr_data      = pat_a5;
      settle();
      chk("one_wr_ready", 256'(wr_req_ready), 256'(1));
      chk("one_wr_we0", 256'(mem_we0), 256'(1));
      chk("one_wr_addr", 256'(mem_address0), 256'(5));
      chk("one_wr_d0", mem_d0, pat_a5);
      tick();
      wr_req_valid = 1'b0;
      wr_data      = '0;
      rd_req_valid = 1'b1;
      rd_addr      = 11'd5;
      settle();
      chk("one_rd_ready", 256'(rd_req_ready), 256'(1));
      chk("one_rd_we0", 256'(mem_we0), 256'(0));
      chk("one_rd_addr", 256'(mem_address0), 256'(5));
      tick();
      rd_req_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         settle();
         chk("one_rsp_valid", 256'(rd_rsp_valid), 256'(k == LAT + 1));
         if (k == LAT + 1) chk("one_rsp_data", rd_rsp_data, pat_a5);
         chk("one_inflight", 256'(rd_inflight), 256'(exp_one[k]));
         tick();
      end

      // preload addresses 0..5 with i*3, then stream six reads
      for (int i = 0; i < 6; i++) begin
         wr_req_valid = 1'b1;
         wr_addr      = AW'(i);
         wr_data      = DW'(i * 3);
         settle();
         chk("pre_wr_ready", 256'(wr_req_ready), 256'(1));
         tick();
      end
      wr_req_valid = 1'b0;
      peak = 0;
      for (int c = 0; c < 11; c++) begin
         rd_req_valid = (c < 6);
         rd_addr      = AW'(c);
         settle();
         if (c < 6) chk("str_rd_ready", 256'(rd_req_ready), 256'(1));
         exp_v = (c >= 3 && c <= 8);
         chk("str_rsp_valid", 256'(rd_rsp_valid), 256'(exp_v));
         if (exp_v) chk("str_rsp_data", rd_rsp_data, DW'((c - 3) * 3));
         chk("str_inflight", 256'(rd_inflight), 256'(exp_inf[c]));
         if (int'(rd_inflight) > peak) peak = int'(rd_inflight);
         tick();
      end
      chk("str_peak", 256'(peak), 256'(LAT + 1));

      // reset while two reads are in flight
      rd_req_valid = 1'b1;
      rd_addr      = 11'd1;
      settle();
      chk("mid_rd0_ready", 256'(rd_req_ready), 256'(1));
      tick();
      rd_addr = 11'd2;
      settle();
      chk("mid_rd1_ready", 256'(rd_req_ready), 256'(1));
      tick();
      reset = 1'b0;
      settle();
      chk("mid_inflight_pre", 256'(rd_inflight), 256'(2));
      chk("mid_rd_ready_rst", 256'(rd_req_ready), 256'(0));
      chk("mid_ce0_rst", 256'(mem_ce0), 256'(0));
      tick();
      reset        = 1'b1;
      rd_req_valid = 1'b0;
      for (int c = 3; c < 9; c++) begin
         settle();
         chk("mid_rsp_valid", 256'(rd_rsp_valid), 256'(0));
         chk("mid_inflight", 256'(rd_inflight), 256'(0));
         tick();
      end

      // boundary address 2047, address 0 must stay untouched
      for (int c = 0; c < 7; c++) begin
         wr_req_valid = (c == 0);
         wr_addr      = 11'd2047;
         wr_data      = '1;
         rd_req_valid = (c == 1 || c == 2);
         rd_addr      = (c == 1) ? 11'd2047 : 11'd0;
         settle();
         if (c == 0) begin
            chk("bnd_wr_ready", 256'(wr_req_ready), 256'(1));
            chk("bnd_wr_addr", 256'(mem_address0), 256'(2047));
         end
         if (c == 1 || c == 2) chk("bnd_rd_ready", 256'(rd_req_ready), 256'(1));
         chk("bnd_rsp_valid", 256'(rd_rsp_valid), 256'(c == 4 || c == 5));
         if (c == 4) chk("bnd_rsp_2047", rd_rsp_data, {DW{1'b1}});
         if (c == 5) chk("bnd_rsp_0", rd_rsp_data, DW'(0));
         tick();
      end
      wr_req_valid = 1'b0;
      wr_data      = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
